// File: rtl/mb8_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mb8_div_seq_if
// Purpose  : Handshake bundle for the mb8_div_seq restoring divider.
//            Request side: in_valid/in_ready with a 2*WIDTH-bit dividend and
//            a WIDTH-bit divisor. Response side: out_valid/out_ready with
//            the quotient, the remainder and the dz/ovf error flags.
// Modports : slave  - the divider (accepts requests, produces results)
//            master - the requester/consumer driving the divider
// Revision : 1.0 - initial release
// ============================================================================
interface mb8_div_seq_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   dz;
  logic                   ovf;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dz, ovf
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz, ovf
  );
endinterface
`default_nettype wire

// File: rtl/mb8_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : mb8_div_seq
// Purpose  : Iterative unsigned restoring divider, one quotient bit per
//            clock. Divides a 2*WIDTH-bit dividend (typically a Booth
//            multiplier product) by a WIDTH-bit divisor and returns a
//            WIDTH-bit quotient and remainder, flagging divide-by-zero (dz)
//            and quotient overflow (ovf).
// Ports    : CLK  - clock, rising edge
//            RST  - synchronous active-high reset
//            bus  - mb8_div_seq_if.slave (request and response handshakes)
// Revision : 1.0 - initial release
// ============================================================================
module mb8_div_seq #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  mb8_div_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_CALC  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CNTW-1:0] c_last_iter = CNTW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH:0]       r_q,     r_d;      // partial remainder, one guard bit
  logic [WIDTH-1:0]     q_q,     q_d;      // low dividend half / quotient bits
  logic [WIDTH-1:0]     d_q,     d_d;      // divisor
  logic [CNTW-1:0]      cnt_q,   cnt_d;
  logic [WIDTH-1:0]     quot_q,  quot_d;
  logic [WIDTH-1:0]     rem_q,   rem_d;
  logic                 dz_q,    dz_d;
  logic                 ovf_q,   ovf_d;

  // One restoring step: shift {R,Q} left, trial-subtract D at WIDTH+1 bits.
  // Since R < D holds on entry, the shifted R fits in WIDTH+1 bits and a
  // borrow always shows up as a set MSB of the difference.
  logic [WIDTH:0]       w_r_shift;
  logic [WIDTH:0]       w_t;
  logic                 w_take;
  logic [WIDTH:0]       w_r_next;
  logic [WIDTH-1:0]     w_q_next;
  logic                 w_d_zero;
  logic                 w_q_ovf;

  assign w_r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign w_t       = w_r_shift - {1'b0, d_q};
  assign w_take    = ~w_t[WIDTH];
  assign w_r_next  = w_take ? w_t : w_r_shift;
  assign w_q_next  = {q_q[WIDTH-2:0], w_take};

  // The quotient only fits in WIDTH bits when the high dividend half is
  // strictly below the divisor.
  assign w_d_zero  = (d_q == '0);
  assign w_q_ovf   = (r_q[WIDTH-1:0] >= d_q);

  // The guard bit of R is kept at zero by construction; it exists so the
  // remainder register mirrors the WIDTH+1-bit trial-subtraction datapath.
  logic unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          r_d     = {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
          q_d     = bus.dividend[WIDTH-1:0];
          d_d     = bus.divisor;
          cnt_d   = '0;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (w_d_zero || w_q_ovf) begin
          // Error results are registered on the first CHECK edge and the
          // response is published on the second, so errors complete two
          // edges after the accept edge. The counter marks the first pass.
          if (cnt_q == '0) begin
            quot_d = '1;
            dz_d   = w_d_zero;
            ovf_d  = ~w_d_zero;
            rem_d  = w_d_zero ? q_q : '0;
            cnt_d  = CNTW'(1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        r_d   = w_r_next;
        q_d   = w_q_next;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == c_last_iter) begin
          quot_d  = w_q_next;
          rem_d   = w_r_next[WIDTH-1:0];
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mb8_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb8_div_seq
// Purpose  : Self-checking bench for mb8_div_seq: directed vectors with
//            hand-computed results, error paths, backpressure, reset during
//            the iteration, then product/operand recovery on random pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mb8_div_seq;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  mb8_div_seq_if #(.WIDTH(W)) bus ();

  mb8_div_seq #(.WIDTH(W), .CNTW(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request; returns #1 after the accept edge.
  task automatic start_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs);
    @(negedge CLK);
    check({tag, ".in_ready"}, bus.in_ready, 1);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_valid(input string tag, input int lat);
    int edges;
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      @(posedge CLK);
      #1;
      edges++;
      check({tag, ".r_msb"}, dut.r_q[W], 0);
    end
    check({tag, ".latency"}, edges, lat);
  endtask

  task automatic check_res(input string tag, input logic [7:0] eq, input logic [7:0] er,
                           input logic edz, input logic eovf);
    check({tag, ".out_valid"}, bus.out_valid, 1);
    check({tag, ".quotient"},  bus.quotient,  eq);
    check({tag, ".remainder"}, bus.remainder, er);
    check({tag, ".dz"},        bus.dz,        edz);
    check({tag, ".ovf"},       bus.ovf,       eovf);
  endtask

  // With out_ready high, DONE lasts one cycle and IDLE follows.
  task automatic finish_hs(input string tag);
    @(posedge CLK);
    #1;
    check({tag, ".out_valid_low"}, bus.out_valid, 0);
    check({tag, ".in_ready_back"}, bus.in_ready,  1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                        input int lat, input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic eovf);
    start_op(tag, dvd, dvs);
    wait_valid(tag, lat);
    check_res(tag, eq, er, edz, eovf);
    finish_hs(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;

    // Reset / idle
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("rst.in_ready",  bus.in_ready,  1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.quotient",  bus.quotient,  8'h00);
    check("rst.remainder", bus.remainder, 8'h00);
    check("rst.dz",        bus.dz,        0);
    check("rst.ovf",       bus.ovf,       0);

    // Directed vectors (hand-computed)
    run_op("exact",   16'h41C4, 8'hB7, 9, 8'h5C, 8'h00, 1'b0, 1'b0);
    run_op("rem",     16'h41D6, 8'hB7, 9, 8'h5C, 8'h12, 1'b0, 1'b0);
    run_op("max",     16'hFE01, 8'hFF, 9, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("maxrem",  16'hFEFF, 8'hFF, 9, 8'hFF, 8'hFE, 1'b0, 1'b0);
    run_op("small",   16'h00FF, 8'h10, 9, 8'h0F, 8'h0F, 1'b0, 1'b0);
    run_op("unit",    16'h00FF, 8'hFF, 9, 8'h01, 8'h00, 1'b0, 1'b0);
    run_op("zero",    16'h0000, 8'h01, 9, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("dz",      16'h1234, 8'h00, 2, 8'hFF, 8'h34, 1'b1, 1'b0);
    run_op("ovf",     16'h8000, 8'h7F, 2, 8'hFF, 8'h00, 1'b0, 1'b1);
    run_op("ovf_eq",  16'h0100, 8'h01, 2, 8'hFF, 8'h00, 1'b0, 1'b1);
    run_op("after_e", 16'h41C4, 8'hB7, 9, 8'h5C, 8'h00, 1'b0, 1'b0);

    // Backpressure: results held, requests ignored while DONE
    bus.out_ready = 1'b0;
    start_op("bp", 16'h41D6, 8'hB7);
    wait_valid("bp", 9);
    check_res("bp", 8'h5C, 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.dividend = 16'h0101;
      bus.divisor  = 8'h01;
      @(posedge CLK);
      #1;
      check("bp.in_ready_low", bus.in_ready, 0);
      check_res("bp.hold", 8'h5C, 8'h12, 1'b0, 1'b0);
    end
    @(negedge CLK);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    finish_hs("bp");

    // Reset during the fourth CALC cycle
    start_op("midrst", 16'h41C4, 8'hB7);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst.in_ready",  bus.in_ready,  1);
    check("midrst.out_valid", bus.out_valid, 0);
    check("midrst.quotient",  bus.quotient,  8'h00);
    check("midrst.remainder", bus.remainder, 8'h00);
    check("midrst.dz",        bus.dz,        0);
    check("midrst.ovf",       bus.ovf,       0);
    check("midrst.cnt",       dut.cnt_q,     0);
    @(negedge CLK);
    RST = 1'b0;
    run_op("post_rst", 16'h41C4, 8'hB7, 9, 8'h5C, 8'h00, 1'b0, 1'b0);

    // Operand recovery from products
    for (int i = 0; i < 3000; i++) begin
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      a = 8'($urandom_range(1, 255));
      b = 8'($urandom_range(0, 255));
      p = 16'(a) * 16'(b);
      run_op("rand", p, a, 9, b, 8'h00, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
